// File: rtl/operand_forward_ctrl_if.sv
// ID-to-EX hazard/forwarding bus: decode-side instruction fields in,
// stall and EX operand-mux selects out.
interface operand_forward_ctrl_if #(
  parameter int REG_AW = 3
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_load;
  logic              flush;
  logic              stall;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              ex_valid;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wr_en, id_rd, id_is_load, flush,
    input  stall, fwd_a, fwd_b, ex_valid
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_wr_en, id_rd, id_is_load, flush,
    output stall, fwd_a, fwd_b, ex_valid
  );
endinterface

// File: rtl/operand_forward_ctrl.sv
// Hazard and forwarding controller between ID and EX: tracks EX/MEM
// destination tags, raises a one-cycle load-use stall, drives operand selects.
module operand_forward_ctrl #(
  parameter int REG_AW      = 3,
  parameter int ZERO_REG_HW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_forward_ctrl_if.slave bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;  // EX/MEM pipeline register
  localparam logic [1:0] SEL_WB  = 2'b10;  // MEM/WB pipeline register

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } ex_tag_t;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
  } mem_tag_t;

  ex_tag_t    ex_tag;
  mem_tag_t   mem_tag;
  logic [1:0] fwd_a_q;
  logic [1:0] fwd_b_q;
  logic       ex_valid_q;

  logic       id_tag_v;
  logic       stall_c;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // Younger producer (EX) is checked first so it wins over MEM.
  function automatic logic [1:0] src_sel(input logic uses, input logic [REG_AW-1:0] src,
                                         input ex_tag_t ex_t, input mem_tag_t mem_t);
    if (uses && ex_t.v && ex_t.rd == src)
      return SEL_MEM;
    else if (uses && mem_t.v && mem_t.rd == src)
      return SEL_WB;
    else
      return SEL_RF;
  endfunction

  assign id_tag_v = bus.id_valid & bus.id_wr_en &
                    ((ZERO_REG_HW == 0) || (bus.id_rd != '0));

  // Only a load still in EX can cause a stall; once it reaches MEM its data forwards.
  assign stall_c = bus.id_valid & ~bus.flush & ex_tag.v & ex_tag.ld &
                   ((bus.id_uses_rs & (bus.id_rs == ex_tag.rd)) |
                    (bus.id_uses_rt & (bus.id_rt == ex_tag.rd)));

  assign sel_a = src_sel(bus.id_uses_rs, bus.id_rs, ex_tag, mem_tag);
  assign sel_b = src_sel(bus.id_uses_rt, bus.id_rt, ex_tag, mem_tag);

  // NOTE: all pipeline state uses non-blocking assignments so every register
  // samples the pre-edge value of ex_tag (mem_tag <= ex_tag relies on this).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_tag     <= '0;
      mem_tag    <= '0;
      fwd_a_q    <= SEL_RF;
      fwd_b_q    <= SEL_RF;
      ex_valid_q <= 1'b0;
    end else begin
      mem_tag <= '{v: ex_tag.v, rd: ex_tag.rd};
      if (bus.flush || stall_c) begin
        ex_tag.v   <= 1'b0;
        fwd_a_q    <= SEL_RF;
        fwd_b_q    <= SEL_RF;
        ex_valid_q <= 1'b0;
      end else begin
        ex_tag     <= '{v: id_tag_v, rd: bus.id_rd, ld: bus.id_is_load};
        fwd_a_q    <= sel_a;
        fwd_b_q    <= sel_b;
        ex_valid_q <= bus.id_valid;
      end
    end
  end

  assign bus.stall    = stall_c;
  assign bus.fwd_a    = fwd_a_q;
  assign bus.fwd_b    = fwd_b_q;
  assign bus.ex_valid = ex_valid_q;

endmodule
